// File: rtl/irq_priority_ctrl.sv
// 8259-style interrupt priority controller: IRR/ISR/IMR, nested/rotating priority, two-pulse INTA.
// Define IRQ_PRIO_ROTATE_EN to enable EOI_ROTATE / SET_PRIO and a writable LOW_PRIO register.
module irq_priority_ctrl #(
    parameter int unsigned N_IRQ    = 8,
    parameter int unsigned IDX_W    = $clog2(N_IRQ),
    parameter logic [7:0]  VEC_BASE = 8'h08
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_IRQ-1:0] IRs,
    input  logic             LEVEL_MODE,
    input  logic             AEOI,
    input  logic             IMR_WE,
    input  logic [N_IRQ-1:0] IMR_DIN,
    input  logic             INTA,
    input  logic             EOI,
    input  logic             EOI_SPECIFIC,
    input  logic             EOI_ROTATE,
    input  logic             SET_PRIO,
    input  logic [IDX_W-1:0] CMD_LEVEL,
    output logic             INT,
    output logic [7:0]       VECTOR,
    output logic             VECTOR_VALID,
    output logic [N_IRQ-1:0] IRR,
    output logic [N_IRQ-1:0] ISR,
    output logic [N_IRQ-1:0] IMR,
    output logic [IDX_W-1:0] LOW_PRIO
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_ACK2 = 2'd2;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IRQ - 1);
    localparam logic [N_IRQ-1:0] ONE  = N_IRQ'(1);

    logic [N_IRQ-1:0] irs_q, irs_qq, irr, isr, imr;
    logic [1:0]       state;
    logic [IDX_W-1:0] w_idx, low_prio;
    logic             spurious, int_q, vector_valid_q;
    logic [7:0]       vector_q;

    logic [N_IRQ-1:0] pend, ack_set, irr_clr, edge_set, eoi_clr, aeoi_clr;
    logic             isr_found, win_found, eoi_hit, cmd_ok, ack_take, ack2_take;
    logic [IDX_W-1:0] isr_top, win_idx, eoi_idx, idx;
    int unsigned      isr_rank, pos;

    // Walk positions in descending priority starting just above LOW_PRIO; first hit is highest-ranked.
    always_comb begin
        pend      = irr & ~imr;
        isr_found = 1'b0;
        isr_rank  = N_IRQ;
        isr_top   = '0;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            pos = 32'(low_prio) + 1 + k;
            if (pos >= N_IRQ) pos = pos - N_IRQ;
            idx = IDX_W'(pos);
            if (!isr_found && isr[idx]) begin
                isr_found = 1'b1;
                isr_rank  = k;
                isr_top   = idx;
            end
        end
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            pos = 32'(low_prio) + 1 + k;
            if (pos >= N_IRQ) pos = pos - N_IRQ;
            idx = IDX_W'(pos);
            if (!win_found && (k < isr_rank) && pend[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        cmd_ok  = 32'(CMD_LEVEL) < N_IRQ;
        eoi_hit = 1'b0;
        eoi_idx = '0;
        if (EOI) begin
            if (EOI_SPECIFIC) begin
                eoi_hit = cmd_ok;
                eoi_idx = CMD_LEVEL;
            end else if (isr_found) begin
                eoi_hit = 1'b1;
                eoi_idx = isr_top;
            end
        end
        eoi_clr   = eoi_hit ? (ONE << eoi_idx) : '0;
        ack_take  = (state == ST_IDLE) && INTA;
        ack2_take = (state == ST_ACK1) && INTA;
        ack_set   = (ack_take && win_found) ? (ONE << win_idx) : '0;
        irr_clr   = LEVEL_MODE ? '0 : ack_set;
        aeoi_clr  = (ack2_take && AEOI && !spurious) ? (ONE << w_idx) : '0;
        edge_set  = irs_q & ~irs_qq;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irs_q          <= '0;
            irs_qq         <= '0;
            irr            <= '0;
            isr            <= '0;
            imr            <= '1;
            state          <= ST_IDLE;
            w_idx          <= '0;
            spurious       <= 1'b0;
            int_q          <= 1'b0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            irs_q          <= IRs;
            irs_qq         <= irs_q;
            irr            <= LEVEL_MODE ? irs_q : ((irr & ~irr_clr) | edge_set);
            isr            <= (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
            if (IMR_WE) imr <= IMR_DIN;
            int_q          <= win_found;
            vector_valid_q <= 1'b0;
            case (state)
                ST_IDLE: if (ack_take) begin
                    state    <= ST_ACK1;
                    w_idx    <= win_found ? win_idx : LAST;
                    spurious <= !win_found;
                end
                ST_ACK1: if (ack2_take) begin
                    state          <= ST_ACK2;
                    vector_q       <= VEC_BASE + 8'(w_idx);
                    vector_valid_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IRQ_PRIO_ROTATE_EN
    // SET_PRIO outranks an EOI rotation, which outranks the ACK2 rotation.
    always_ff @(posedge CLK) begin
        if (RST)                          low_prio <= LAST;
        else if (SET_PRIO && cmd_ok)      low_prio <= CMD_LEVEL;
        else if (eoi_hit && EOI_ROTATE)   low_prio <= eoi_idx;
        else if (ack2_take && EOI_ROTATE) low_prio <= w_idx;
    end
`else
    logic unused_rot;
    assign unused_rot = ^{SET_PRIO, EOI_ROTATE};
    assign low_prio   = LAST;
`endif

    assign INT          = int_q;
    assign VECTOR       = vector_q;
    assign VECTOR_VALID = vector_valid_q;
    assign IRR          = irr;
    assign ISR          = isr;
    assign IMR          = imr;
    assign LOW_PRIO     = low_prio;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scenario tests for irq_priority_ctrl; vectors are scoreboarded through a queue checked by a monitor.
module tb_irq_priority_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] IRs = '0;
    logic       LEVEL_MODE = 1'b0, AEOI = 1'b0, IMR_WE = 1'b0, INTA = 1'b0;
    logic [7:0] IMR_DIN = '0;
    logic       EOI = 1'b0, EOI_SPECIFIC = 1'b0, EOI_ROTATE = 1'b0, SET_PRIO = 1'b0;
    logic [2:0] CMD_LEVEL = '0;
    logic       INT, VECTOR_VALID;
    logic [7:0] VECTOR, IRR, ISR, IMR;
    logic [2:0] LOW_PRIO;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    irq_priority_ctrl #(.N_IRQ(8), .VEC_BASE(8'h08)) dut (
        .CLK(CLK), .RST(RST), .IRs(IRs), .LEVEL_MODE(LEVEL_MODE), .AEOI(AEOI),
        .IMR_WE(IMR_WE), .IMR_DIN(IMR_DIN), .INTA(INTA), .EOI(EOI),
        .EOI_SPECIFIC(EOI_SPECIFIC), .EOI_ROTATE(EOI_ROTATE), .SET_PRIO(SET_PRIO),
        .CMD_LEVEL(CMD_LEVEL), .INT(INT), .VECTOR(VECTOR), .VECTOR_VALID(VECTOR_VALID),
        .IRR(IRR), .ISR(ISR), .IMR(IMR), .LOW_PRIO(LOW_PRIO)
    );

    always #5 CLK = ~CLK;

    // Every VECTOR_VALID strobe must match the oldest expected vector.
    always @(negedge CLK) begin
        if (VECTOR_VALID) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vector: got VECTOR_VALID with VECTOR=%h, none expected", VECTOR);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (VECTOR !== e) begin
                    n_fail++;
                    $display("FAIL vector: got %h expected %h", VECTOR, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(2);
        RST = 1'b0;
    endtask

    task automatic write_imr(input logic [7:0] v);
        IMR_WE = 1'b1; IMR_DIN = v;
        step(1);
        IMR_WE = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] exp_vec);
        INTA = 1'b1;
        step(1);
        exp_q.push_back(exp_vec);
        step(1);
        INTA = 1'b0;
        step(1);
    endtask

    task automatic do_eoi();
        EOI = 1'b1;
        step(1);
        EOI = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (IRR !== 8'h00) begin n_fail++; $display("FAIL reset_irr: got %h expected 00", IRR); end
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL reset_isr: got %h expected 00", ISR); end
        n_cmp++; if (IMR !== 8'hFF) begin n_fail++; $display("FAIL reset_imr: got %h expected ff", IMR); end
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", INT); end
        n_cmp++; if (VECTOR !== 8'h00) begin n_fail++; $display("FAIL reset_vector: got %h expected 00", VECTOR); end
        n_cmp++; if (LOW_PRIO !== 3'd7) begin n_fail++; $display("FAIL reset_low_prio: got %0d expected 7", LOW_PRIO); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        write_imr(8'h00);
        IRs = 8'h24;
        step(2);
        n_cmp++; if (IRR !== 8'h24) begin n_fail++; $display("FAIL fixed_irr: got %h expected 24", IRR); end
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL fixed_int_early: got %b expected 0", INT); end
        step(1);
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL fixed_int: got %b expected 1", INT); end
        do_ack(8'h0A);
        n_cmp++; if (ISR !== 8'h04) begin n_fail++; $display("FAIL fixed_isr: got %h expected 04", ISR); end
        n_cmp++; if (IRR !== 8'h20) begin n_fail++; $display("FAIL fixed_irr_clr: got %h expected 20", IRR); end
        do_eoi();
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL fixed_eoi: got %h expected 00", ISR); end
        do_ack(8'h0D);
        n_cmp++; if (ISR !== 8'h20) begin n_fail++; $display("FAIL fixed_isr2: got %h expected 20", ISR); end
        IRs = 8'h00;
    endtask

    task automatic test_mask();
        do_reset();
        IRs = 8'h01;
        step(3);
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL mask_int_masked: got %b expected 0", INT); end
        write_imr(8'hFE);
        n_cmp++; if (IMR !== 8'hFE) begin n_fail++; $display("FAIL mask_imr: got %h expected fe", IMR); end
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL mask_old_imr: got %b expected 0", INT); end
        step(1);
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL mask_unmasked: got %b expected 1", INT); end
        do_ack(8'h08);
        IRs = 8'h00;
    endtask

    task automatic test_nesting();
        do_reset();
        write_imr(8'h00);
        IRs = 8'h10;
        step(3);
        do_ack(8'h0C);
        n_cmp++; if (ISR !== 8'h10) begin n_fail++; $display("FAIL nest_isr: got %h expected 10", ISR); end
        IRs = 8'h50;
        step(3);
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL nest_ir6_blocked: got %b expected 0", INT); end
        IRs = 8'h54;
        step(2);
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL nest_ir2_early: got %b expected 0", INT); end
        step(1);
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL nest_ir2_int: got %b expected 1", INT); end
        do_ack(8'h0A);
        n_cmp++; if (ISR !== 8'h14) begin n_fail++; $display("FAIL nest_isr2: got %h expected 14", ISR); end
        do_eoi();
        n_cmp++; if (ISR !== 8'h10) begin n_fail++; $display("FAIL nest_eoi1: got %h expected 10", ISR); end
        do_eoi();
        step(1);
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL nest_ir6_released: got %b expected 1", INT); end
        do_ack(8'h0E);
        IRs = 8'h00;
    endtask

    task automatic test_specific_eoi();
        do_reset();
        write_imr(8'h00);
        IRs = 8'h11;
        step(3);
        do_ack(8'h08);
        EOI_SPECIFIC = 1'b1; CMD_LEVEL = 3'd4;
        do_eoi();
        n_cmp++; if (ISR !== 8'h01) begin n_fail++; $display("FAIL spec_eoi_other: got %h expected 01", ISR); end
        CMD_LEVEL = 3'd0;
        do_eoi();
        EOI_SPECIFIC = 1'b0;
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL spec_eoi: got %h expected 00", ISR); end
        do_ack(8'h0C);
        IRs = 8'h00;
    endtask

    task automatic test_aeoi();
        do_reset();
        write_imr(8'h00);
        AEOI = 1'b1;
        IRs = 8'h08;
        step(3);
        do_ack(8'h0B);
        AEOI = 1'b0;
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr: got %h expected 00", ISR); end
        n_cmp++; if (IRR !== 8'h00) begin n_fail++; $display("FAIL aeoi_irr: got %h expected 00", IRR); end
        IRs = 8'h00;
    endtask

    task automatic test_spurious();
        do_reset();
        write_imr(8'h00);
        LEVEL_MODE = 1'b1;
        IRs = 8'h02;
        step(1);
        IRs = 8'h00;
        step(1);
        n_cmp++; if (IRR !== 8'h02) begin n_fail++; $display("FAIL spur_irr: got %h expected 02", IRR); end
        step(1);
        n_cmp++; if (INT !== 1'b1) begin n_fail++; $display("FAIL spur_int: got %b expected 1", INT); end
        step(1);
        n_cmp++; if (INT !== 1'b0) begin n_fail++; $display("FAIL spur_int_drop: got %b expected 0", INT); end
        do_ack(8'h0F);
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL spur_isr: got %h expected 00", ISR); end
        LEVEL_MODE = 1'b0;
    endtask

    task automatic test_rotation();
        logic [2:0] exp_lp, exp_sp;
        logic [7:0] exp_v;
`ifdef IRQ_PRIO_ROTATE_EN
        exp_lp = 3'd2; exp_v = 8'h0B; exp_sp = 3'd5;
`else
        exp_lp = 3'd7; exp_v = 8'h08; exp_sp = 3'd7;
`endif
        do_reset();
        write_imr(8'h00);
        IRs = 8'h04;
        step(3);
        do_ack(8'h0A);
        EOI_ROTATE = 1'b1;
        do_eoi();
        EOI_ROTATE = 1'b0;
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL rot_isr: got %h expected 00", ISR); end
        n_cmp++; if (LOW_PRIO !== exp_lp) begin n_fail++; $display("FAIL rot_low_prio: got %0d expected %0d", LOW_PRIO, exp_lp); end
        IRs = 8'h09;
        step(3);
        do_ack(exp_v);
        SET_PRIO = 1'b1; CMD_LEVEL = 3'd5;
        step(1);
        SET_PRIO = 1'b0;
        n_cmp++; if (LOW_PRIO !== exp_sp) begin n_fail++; $display("FAIL set_prio: got %0d expected %0d", LOW_PRIO, exp_sp); end
        IRs = 8'h00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_imr(8'h00);
        IRs = 8'h02;
        step(3);
        INTA = 1'b1;
        step(1);
        INTA = 1'b0;
        n_cmp++; if (ISR !== 8'h02) begin n_fail++; $display("FAIL mid_isr_ack1: got %h expected 02", ISR); end
        do_reset();
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL mid_isr: got %h expected 00", ISR); end
        n_cmp++; if (IMR !== 8'hFF) begin n_fail++; $display("FAIL mid_imr: got %h expected ff", IMR); end
        n_cmp++; if (VECTOR_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", VECTOR_VALID); end
        step(3);
        do_ack(8'h0F);
        n_cmp++; if (ISR !== 8'h00) begin n_fail++; $display("FAIL mid_spur_isr: got %h expected 00", ISR); end
        IRs = 8'h00;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_mask();
        test_nesting();
        test_specific_eoi();
        test_aeoi();
        test_spurious();
        test_rotation();
        test_reset_mid();
        step(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_vectors: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_priority_ctrl.md
# irq_priority_ctrl

Clocked, parametrised successor to the 8259-style priority logic. It holds IRR, ISR and IMR for `N_IRQ` request lines and resolves priority in fully-nested or rotating mode. It runs the two-pulse INTA acknowledge sequence and emits the vector, with AEOI, non-specific EOI, specific EOI and set-priority commands. It sits between the request pins and the control-logic/bus block.

## Interface
- `N_IRQ`, 8: number of request lines, legal range 2..16.
- `IDX_W`, `$clog2(N_IRQ)`: index width, derived; never overridden.
- `VEC_BASE`, 8'h08: vector base; `VECTOR = VEC_BASE + index`, mod 256.

Ports:
- `CLK`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `IRs`  in  N_IRQ  raw request lines.
- `LEVEL_MODE`  in  1  1 = level-triggered, 0 = edge-triggered.
- `AEOI`  in  1  automatic EOI on the second INTA.
- `IMR_WE`, `IMR_DIN`  in  1 / N_IRQ  mask write.
- `INTA`  in  1  one-cycle acknowledge pulse from control logic.
- `EOI`, `EOI_SPECIFIC`, `EOI_ROTATE`, `SET_PRIO`  in  1 each  one-cycle command strobes.
- `CMD_LEVEL`  in  IDX_W  level operand for the specific EOI and `SET_PRIO` commands.
- `INT`  out  1  interrupt request to the CPU, registered.
- `VECTOR`  out  8  vector; valid only while `VECTOR_VALID` is high.
- `VECTOR_VALID`  out  1  one-cycle strobe on the second INTA.
- `IRR`, `ISR`, `IMR`  out  N_IRQ  register readback.
- `LOW_PRIO`  out  IDX_W  current lowest-priority index.

## Operation
- **Request capture**
  - `IRs` is registered into `irs_q`.
  - Edge mode: the IRR bit sets when `irs_q` is 1 and its previous value was 0. The bit clears on ACK1 for the winning index.
  - Level mode: `IRR = irs_q`, with no clear on acknowledge.
  - If a set and a clear hit the same IRR bit in the same cycle, the set wins.
- **Priority order**
  - Highest priority is index `LOW_PRIO+1 mod N_IRQ`, and priority descends cyclically from there.
  - Reset value of `LOW_PRIO` is `N_IRQ-1`, so IR0 is highest.
- **Winner selection**
  - A candidate is any `IRR & ~IMR` bit that ranks strictly above the highest set ISR bit; with ISR empty, every unmasked request is a candidate.
  - The winner is the highest-ranked candidate.
  - `INT` is set when a winner exists.
- **Acknowledge FSM**: states IDLE, ACK1, ACK2.
  - IDLE to ACK1 on `INTA`.
    - With a winner: latch its index `w`, set `ISR[w]`, clear `IRR[w]` in edge mode.
    - With no winner (spurious): latch `w = N_IRQ-1`, leave ISR untouched.
  - ACK1 to ACK2 on the second `INTA`: drive `VECTOR = VEC_BASE+w` and `VECTOR_VALID = 1` for one cycle.
    - If `AEOI` is set and the acknowledge was not spurious, clear `ISR[w]`.
    - With rotation compiled in, `EOI_ROTATE` held high at that edge sets `LOW_PRIO = w`.
  - ACK2 returns to IDLE on the next cycle.
  - `INTA` pulses are only recognised in IDLE and ACK1.
- **EOI commands**
  - Non-specific `EOI`: clear the highest-ranked set ISR bit; no effect when ISR is empty.
  - `EOI` with `EOI_SPECIFIC`: clear `ISR[CMD_LEVEL]`.
  - `EOI` with `EOI_ROTATE`: also set `LOW_PRIO` to the cleared index.
  - `SET_PRIO` alone: `LOW_PRIO = CMD_LEVEL`.
- **Same-cycle events**
  - `ISR_next = (ISR & ~eoi_clr & ~aeoi_clr) | ack_set`.
  - An `IMR` write takes effect next cycle; winner selection in that cycle uses the old IMR.
  - `EOI` and `SET_PRIO` in the same cycle: `SET_PRIO` wins for `LOW_PRIO`.
- **Reset**
  - Reset values: `IRR = ISR = 0`, `IMR = all 1s`, FSM IDLE, `INT = 0`, `VECTOR = 0`, `VECTOR_VALID = 0`, `LOW_PRIO = N_IRQ-1`, `irs_q = 0`.
  - Reset mid-handshake abandons the cycle and produces no vector.

## Timing
- `IRs` rises before edge 1:
  - edge 1: `irs_q = 1`
  - edge 2: `IRR` bit set
  - edge 3: `INT = 1` (if unmasked)
- `INTA` at edge k sets ISR at edge k; `INT` updates at edge k+1.
- Second `INTA` at edge m: `VECTOR_VALID` is high during cycle m to m+1.
- An `EOI` at edge k is visible on `ISR` after edge k; `INT` re-evaluates at edge k+1.
- `CMD_LEVEL` values ≥ `N_IRQ` are ignored.

## Configuration
- `IRQ_PRIO_ROTATE_EN`
  - Defined: `EOI_ROTATE`, `SET_PRIO` and the ACK2 rotation are active, and `LOW_PRIO` is a register.
  - Undefined: `LOW_PRIO` is the constant `N_IRQ-1` (fixed fully-nested order), and `SET_PRIO` and `EOI_ROTATE` are ignored.

## Test plan
- **Fixed priority**: N_IRQ=8, IMR=0, edge mode, `IRs = 8'h24`.
  - INTA, INTA gives `VECTOR = 8'h0A` and `ISR = 8'h04`.
  - Non-specific EOI, then INTA, INTA gives `VECTOR = 8'h0D`.
- **Nesting**: with `ISR = 8'h10`, raise IR6 then IR2.
  - IR6 never raises `INT`; IR2 raises `INT` at edge 3.
- **AEOI**: `AEOI = 1`, raise IR3, then INTA, INTA.
  - `VECTOR = 8'h0B`, `ISR = 0` the cycle after ACK2, `IRR = 0`.
- **Spurious acknowledge**: IR1 pulses high for one cycle in level mode, then INTA.
  - `VECTOR = 8'h0F`, ISR unchanged.
- **Rotation** (`IRQ_PRIO_ROTATE_EN` defined): service IR2 and issue EOI with `EOI_ROTATE`.
  - `LOW_PRIO = 2`; with `IRs = 8'h09`, the next vector is `8'h0B`.
- **Reset mid-handshake**: assert `RST` between ACK1 and ACK2.
  - `ISR = 0`, `IMR = 8'hFF`, no `VECTOR_VALID`, and a later INTA gives a spurious vector.
